instr_queue_register: RTL and testbench
=======================================

# instr_queue_register

Parametrised instruction queue register that replaces the single-entry, IRWrite-gated instruction register in the multi-cycle datapath. It buffers up to DEPTH fetched 32-bit instructions with their PCs in FIFO order. Fetch and decode are decoupled with valid/ready handshakes. The head entry is presented to decode as pre-split MIPS fields. A flush input discards all buffered entries on a branch, jump or exception redirect.

## Interface
Parameters:
- DEPTH, 4: number of entries. Must be a power of two and at least 2.
- PC_WIDTH, 32: width of the PC stored alongside each instruction.
- CNT_WIDTH, $clog2(DEPTH+1): width of Count. Derived; do not override.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Flush  in  1  synchronous discard of all entries.
- In_Valid  in  1  fetch presents Instruction/In_PC.
- In_Ready  out  1  queue can accept an entry this cycle.
- Instruction  in  32  fetched instruction word.
- In_PC  in  PC_WIDTH  PC of Instruction.
- Out_Valid  out  1  head entry valid.
- Out_Ready  in  1  decode consumes the head entry (successor of IRWrite).
- Out_PC  out  PC_WIDTH  PC of the head entry.
- Instr31_26  out  6  opcode of the head entry.
- Instr25_21  out  5  rs of the head entry.
- Instr20_16  out  5  rt of the head entry.
- Instr15_11  out  5  rd of the head entry.
- Instr15_0  out  16  immediate of the head entry.
- Instr5_0  out  6  funct of the head entry.
- Count  out  CNT_WIDTH  number of occupied entries.

## Operation
- Storage: a circular buffer of DEPTH entries, each {instruction[31:0], pc}, addressed by a write pointer and a read pointer of $clog2(DEPTH) bits. Pointers wrap naturally from DEPTH-1 to 0.
- Count register rules:
  - Empty when Count==0; full when Count==DEPTH.
  - In_Ready = (Count != DEPTH). It is registered state only; there is no combinational path from Out_Ready.
  - Out_Valid = (Count != 0).
- Push: when In_Valid && In_Ready, write the entry at wr_ptr and increment wr_ptr. In_Valid while In_Ready is low is backpressure: the entry is not written, and fetch must hold the entry.
- Pop: when Out_Valid && Out_Ready, increment rd_ptr. Out_Ready while empty is ignored.
- Simultaneous push and pop: both pointers advance and Count is unchanged. This is legal at any non-full occupancy. When full, push is blocked and pop proceeds.
- Output fields:
  - Fields are decoded combinationally from the entry at rd_ptr. Instr15_11 = [15:11] and Instr5_0 = [5:0]; the other fields keep their existing bit ranges.
  - When Out_Valid is 0, all field outputs and Out_PC are forced to 0.
- Priority per cycle: Reset > Flush > push/pop.
  - Flush sets wr_ptr, rd_ptr and Count to 0. Any push or pop in the same cycle is discarded.
  - Storage contents need not be cleared.
- Reset: same effect as Flush. Storage is also cleared to 0.
- Count arithmetic: unsigned, CNT_WIDTH bits. The handshake rules guarantee it never exceeds DEPTH and never underflows.

## Timing
- Reset values: In_Ready=1, Out_Valid=0, Count=0, and all field outputs plus Out_PC=0.
- Latency: an entry pushed at edge N is visible on the outputs, with Out_Valid=1, after edge N (one cycle). There is no same-cycle bypass.
- Pop at edge N: the next entry, or zeros if the queue is now empty, appears after edge N.
- Throughput: one push and one pop per cycle sustained.
- Full/empty transitions:
  - In_Ready deasserts the cycle after the push that makes Count==DEPTH.
  - In_Ready reasserts the cycle after the first pop from full.
- Flush or Reset asserted at edge N: after edge N, Count=0, Out_Valid=0 and In_Ready=1. An entry pushed at edge N+1 is visible after edge N+1.
- Reset or Flush mid-stream, including while full or during simultaneous push/pop, always yields an empty queue. No entry survives.

## Test plan
- Reset then idle: all outputs are 0, In_Ready=1 and Count=0. Out_Ready=1 while empty leaves Count at 0.
- Single entry: push 0x012A4020 (add $t0,$t1,$t2) with PC 0x00400000 → next cycle Out_Valid=1 and Out_PC=0x00400000. Fields read Instr31_26=0, Instr25_21=9, Instr20_16=10, Instr15_11=8, Instr5_0=0x20 and Instr15_0=0x4020.
- Fill and order (DEPTH=4): push 4 entries with Out_Ready=0 → Count=4 and In_Ready=0. A 5th In_Valid is not accepted. Popping returns the 4 entries in push order, and In_Ready=1 after the first pop.
- Streaming wrap: hold In_Valid=Out_Ready=1 for 10 cycles with incrementing PCs → Count stays at 1 after the first cycle. All 10 PCs appear in order across the pointer wrap.
- Simultaneous at full: Count=4, In_Valid=1, Out_Ready=1 → pop only. Count=3 and the push is blocked.
- Flush priority: Count=3, assert Flush together with In_Valid and Out_Ready → next cycle Count=0, Out_Valid=0 and outputs=0. A push on the following cycle appears one cycle later.

Source files
------------

// File: rtl/instr_queue_register.sv
// Purpose: FIFO of fetched instructions with PCs; head entry exposed as pre-split MIPS fields.
// Latency: a pushed entry appears on the outputs one cycle after its push edge; no bypass.
// Backpressure: In_Ready is low only when full (registered); Out_Ready while empty is ignored.
module instr_queue_register #(
    parameter int DEPTH     = 4,
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Flush,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    input  logic [31:0]          Instruction,
    input  logic [PC_WIDTH-1:0]  In_PC,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic [PC_WIDTH-1:0]  Out_PC,
    output logic [5:0]           Instr31_26,
    output logic [4:0]           Instr25_21,
    output logic [4:0]           Instr20_16,
    output logic [4:0]           Instr15_11,
    output logic [15:0]          Instr15_0,
    output logic [5:0]           Instr5_0,
    output logic [CNT_WIDTH-1:0] Count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0]         instr;
        logic [PC_WIDTH-1:0] pc;
    } entry_t;

    entry_t               mem_q [DEPTH];
    entry_t               mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 push, pop;
    entry_t               head;

    // Handshake status comes straight from the registered occupancy count.
    assign In_Ready  = (count_q != CNT_WIDTH'(DEPTH));
    assign Out_Valid = (count_q != '0);
    assign Count     = count_q;

    // Qualified transfers; a flush cancels both in the same cycle.
    assign push = In_Valid && In_Ready && !Flush;
    assign pop  = Out_Valid && Out_Ready && !Flush;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{instr: Instruction, pc: In_PC};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_WIDTH'(1);
                2'b01:   count_d = count_q - CNT_WIDTH'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset also scrubs storage so stale words never leak.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Head decode; everything reads zero while the queue is empty.
    always_comb begin
        head = Out_Valid ? mem_q[rd_ptr_q] : '0;
        Out_PC     = head.pc;
        Instr31_26 = head.instr[31:26];
        Instr25_21 = head.instr[25:21];
        Instr20_16 = head.instr[20:16];
        Instr15_11 = head.instr[15:11];
        Instr15_0  = head.instr[15:0];
        Instr5_0   = head.instr[5:0];
    end

endmodule

// File: tb/tb_instr_queue_register.sv
module tb_instr_queue_register;

    localparam int DEPTH = 4;
    localparam int PCW   = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           reset, flush, in_valid, out_ready;
    logic           in_ready, out_valid;
    logic [31:0]    instruction;
    logic [PCW-1:0] in_pc, out_pc;
    logic [5:0]     i31_26, i5_0;
    logic [4:0]     i25_21, i20_16, i15_11;
    logic [15:0]    i15_0;
    logic [CW-1:0]  count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_queue_register #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
        .Clk(clk), .Reset(reset), .Flush(flush),
        .In_Valid(in_valid), .In_Ready(in_ready),
        .Instruction(instruction), .In_PC(in_pc),
        .Out_Valid(out_valid), .Out_Ready(out_ready), .Out_PC(out_pc),
        .Instr31_26(i31_26), .Instr25_21(i25_21), .Instr20_16(i20_16),
        .Instr15_11(i15_11), .Instr15_0(i15_0), .Instr5_0(i5_0),
        .Count(count)
    );

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; out_ready = 0; flush = 0;
        instruction = '0; in_pc = '0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        tick(); tick();
        checks++; if (count !== 0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if ({out_pc, i31_26, i25_21, i20_16, i15_11, i15_0, i5_0} !== '0) begin
            errors++; $display("FAIL reset_fields got pc=%h f=%h exp all zero", out_pc, i15_0); end
        reset = 0;
        out_ready = 1;
        tick();
        checks++; if (count !== 0) begin errors++; $display("FAIL empty_pop_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_pop_valid got=%b exp=0", out_valid); end
        out_ready = 0;
    endtask

    task automatic test_single();
        in_valid = 1; instruction = 32'h012A4020; in_pc = 32'h0040_0000;
        tick();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if (out_pc !== 32'h0040_0000) begin errors++; $display("FAIL single_pc got=%h exp=00400000", out_pc); end
        checks++; if (i31_26 !== 6'd0) begin errors++; $display("FAIL single_op got=%0d exp=0", i31_26); end
        checks++; if (i25_21 !== 5'd9) begin errors++; $display("FAIL single_rs got=%0d exp=9", i25_21); end
        checks++; if (i20_16 !== 5'd10) begin errors++; $display("FAIL single_rt got=%0d exp=10", i20_16); end
        checks++; if (i15_11 !== 5'd8) begin errors++; $display("FAIL single_rd got=%0d exp=8", i15_11); end
        checks++; if (i5_0 !== 6'h20) begin errors++; $display("FAIL single_funct got=%h exp=20", i5_0); end
        checks++; if (i15_0 !== 16'h4020) begin errors++; $display("FAIL single_imm got=%h exp=4020", i15_0); end
        checks++; if (count !== 1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
        out_ready = 1;
        tick();
        out_ready = 0;
        checks++; if (out_valid !== 1'b0 || out_pc !== 0 || i15_0 !== 0) begin
            errors++; $display("FAIL single_drain got valid=%b pc=%h imm=%h exp 0/0/0", out_valid, out_pc, i15_0); end
    endtask

    task automatic test_fill_order();
        for (int k = 0; k < DEPTH; k++) begin
            in_valid = 1; instruction = 32'hA000_0000 + k; in_pc = 32'h100 + 4 * k;
            tick();
            checks++; if (count !== k + 1) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", k, count, k + 1); end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        instruction = 32'hDEAD_BEEF; in_pc = 32'h999;
        tick();
        in_valid = 0;
        checks++; if (count !== 4) begin errors++; $display("FAIL fifth_push_count got=%0d exp=4", count); end
        checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL fifth_push_head got=%h exp=100", out_pc); end
        out_ready = 1;
        for (int k = 0; k < DEPTH; k++) begin
            checks++; if (out_pc !== 32'h100 + 4 * k || i15_0 !== 16'(k)) begin
                errors++; $display("FAIL pop_order[%0d] got pc=%h imm=%h exp pc=%h imm=%h", k, out_pc, i15_0, 32'h100 + 4 * k, k); end
            tick();
            if (k == 0) begin
                checks++; if (in_ready !== 1'b1 || count !== 3) begin
                    errors++; $display("FAIL first_pop got rdy=%b cnt=%0d exp rdy=1 cnt=3", in_ready, count); end
            end
        end
        out_ready = 0;
        checks++; if (count !== 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL fill_drained got cnt=%0d vld=%b exp 0/0", count, out_valid); end
    endtask

    task automatic test_stream_wrap();
        in_valid = 1; out_ready = 1;
        for (int k = 0; k < 10; k++) begin
            instruction = 32'h2000_0000 + k; in_pc = 32'h4000 + 4 * k;
            tick();
            checks++; if (count !== 1 || out_pc !== 32'h4000 + 4 * k) begin
                errors++; $display("FAIL stream[%0d] got cnt=%0d pc=%h exp cnt=1 pc=%h", k, count, out_pc, 32'h4000 + 4 * k); end
        end
        in_valid = 0;
        tick();
        out_ready = 0;
        checks++; if (count !== 0) begin errors++; $display("FAIL stream_drain got=%0d exp=0", count); end
    endtask

    task automatic test_full_simul();
        for (int k = 0; k < DEPTH; k++) begin
            in_valid = 1; instruction = 32'hB000_0000 + k; in_pc = 32'h800 + 4 * k;
            tick();
        end
        instruction = 32'hB000_00FF; in_pc = 32'hFFC;
        out_ready = 1;
        tick();
        in_valid = 0;
        checks++; if (count !== 3) begin errors++; $display("FAIL full_simul_count got=%0d exp=3", count); end
        checks++; if (out_pc !== 32'h804) begin errors++; $display("FAIL full_simul_head got=%h exp=804", out_pc); end
        for (int k = 1; k < DEPTH; k++) begin
            checks++; if (out_pc !== 32'h800 + 4 * k) begin
                errors++; $display("FAIL full_simul_order[%0d] got=%h exp=%h", k, out_pc, 32'h800 + 4 * k); end
            tick();
        end
        out_ready = 0;
        checks++; if (count !== 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL full_simul_blocked got cnt=%0d vld=%b exp 0/0", count, out_valid); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1; instruction = 32'hC000_0000 + k; in_pc = 32'hC00 + 4 * k;
            tick();
        end
        flush = 1; out_ready = 1; instruction = 32'hC000_00AA; in_pc = 32'hCAA;
        tick();
        flush = 0; in_valid = 0; out_ready = 0;
        checks++; if (count !== 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state got cnt=%0d vld=%b rdy=%b exp 0/0/1", count, out_valid, in_ready); end
        checks++; if (out_pc !== 0 || i15_0 !== 0 || i31_26 !== 0) begin
            errors++; $display("FAIL flush_fields got pc=%h imm=%h exp 0/0", out_pc, i15_0); end
        in_valid = 1; instruction = 32'h8D09_0004; in_pc = 32'hD00;
        tick();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hD00 || count !== 1) begin
            errors++; $display("FAIL post_flush_push got vld=%b pc=%h cnt=%0d exp 1/d00/1", out_valid, out_pc, count); end
        checks++; if (i31_26 !== 6'h23 || i25_21 !== 5'd8 || i20_16 !== 5'd9 || i15_0 !== 16'h0004) begin
            errors++; $display("FAIL post_flush_fields got op=%h rs=%0d rt=%0d imm=%h exp 23/8/9/0004", i31_26, i25_21, i20_16, i15_0); end
    endtask

    task automatic test_reset_full();
        for (int k = 0; k < DEPTH; k++) begin
            in_valid = 1; instruction = 32'hE000_0000 + k; in_pc = 32'hE00 + 4 * k;
            tick();
        end
        reset = 1; out_ready = 1;
        tick();
        reset = 0; in_valid = 0; out_ready = 0;
        checks++; if (count !== 0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 0) begin
            errors++; $display("FAIL reset_full got cnt=%0d vld=%b rdy=%b pc=%h exp 0/0/1/0", count, out_valid, in_ready, out_pc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_fill_order();
        test_stream_wrap();
        test_full_simul();
        test_flush();
        test_reset_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
